mcp3_fifo512x064_ctl: RTL

MCP3_FIFO512X064_CTL -- requirements
Module: mcp3_fifo512x064_ctl

---
 rtl/mcp3_fifo512x064_ctl.sv | 71 +++++++
 1 files changed

// File: rtl/mcp3_fifo512x064_ctl.sv
// mcp3_fifo512x064_ctl: 512x64 FWFT FIFO controller around an external 1-cycle-latency block RAM
module mcp3_fifo512x064_ctl #(
    parameter int AFULL_THRESH = 448
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push_valid,
    input  logic [63:0] push_data,
    output logic        push_ready,
    output logic        pop_valid,
    output logic [63:0] pop_data,
    input  logic        pop_ready,
    output logic [9:0]  count,
    output logic        empty,
    output logic        full,
    output logic        almost_full,
    output logic        ram_wren,
    output logic [8:0]  ram_wrad,
    output logic [63:0] ram_data,
    output logic        ram_rden,
    output logic [8:0]  ram_rdad,
    input  logic [63:0] ram_q
);
    logic [8:0]  wrptr, rdptr;
    logic [9:0]  ram_cnt;
    logic        inflight;
    logic [1:0]  ob_cnt;
    logic [63:0] ob0, ob1;
    logic        pop;
    logic [1:0]  base;

    assign push_ready  = (count < 10'd512) && !flush && !reset;
    assign ram_wren    = push_valid && push_ready;
    assign ram_wrad    = wrptr;
    assign ram_data    = push_data;
    assign pop_valid   = ob_cnt != 2'd0;
    assign pop_data    = ob0;
    assign pop         = pop_valid && pop_ready;
    assign ram_rden    = (ram_cnt != 10'd0) && (({1'b0, ob_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2) && !flush && !reset;
    assign ram_rdad    = rdptr;
    assign base        = ob_cnt - {1'b0, pop};
    assign empty       = count == 10'd0;
    assign full        = count == 10'd512;
    assign almost_full = count >= 10'(AFULL_THRESH);

    // Pointers and occupancy bookkeeping; reset and flush both discard everything
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrptr    <= '0;
            rdptr    <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= '0;
            count    <= '0;
        end else begin
            wrptr    <= wrptr + {8'd0, ram_wren};
            rdptr    <= rdptr + {8'd0, ram_rden};
            ram_cnt  <= ram_cnt + {9'd0, ram_wren} - {9'd0, ram_rden};
            inflight <= ram_rden;
            ob_cnt   <= base + {1'b0, inflight};
            count    <= count + {9'd0, ram_wren} - {9'd0, pop};
        end
    end

    // Head/tail slots: shift on pop, land returning RAM data in the first free slot
    always_ff @(posedge clk) begin
        ob0 <= (inflight && base == 2'd0) ? ram_q : pop ? ob1 : ob0;
        ob1 <= (inflight && base != 2'd0) ? ram_q : ob1;
    end
endmodule
